// File: rtl/pwm_multi_ch_pkg.sv
// Shared register map, bit positions and address helper for pwm_multi_ch.
package pwm_multi_ch_pkg;

    // Word indices relative to BASE
    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_PRESC  = 1;
    localparam int unsigned REG_PERIOD = 2;
    localparam int unsigned REG_STATUS = 3;
    localparam int unsigned REG_DUTY0  = 4;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_IRQ_BIT = 1;
    localparam int unsigned CTRL_POL_LSB = 8;

    // STATUS bit positions
    localparam int unsigned STAT_PEF_BIT = 0;
    localparam int unsigned STAT_UPD_BIT = 1;

    // Word offset of an address from BASE; below-BASE addresses wrap to a huge index
    function automatic logic [29:0] word_index(input logic [29:0] addr_w, input logic [29:0] base_w);
        return addr_w - base_w;
    endfunction

endpackage

// File: rtl/pwm_multi_ch_channel.sv
// One PWM channel: active duty register, shadow load, comparator, polarity, output flop.
module pwm_multi_ch_channel #(
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          res,
    input  logic          load,
    input  logic          en,
    input  logic          pol,
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] duty_sh,
    output logic          pwm,
    output logic          upd_c
);

    logic [CW-1:0] duty_act;

    // Active duty reloads on the shared load strobe; output is compare result xor polarity
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            duty_act <= '0;
            pwm      <= 1'b0;
        end else begin
            if (load) begin
                duty_act <= duty_sh;
            end
            pwm <= en ? ((cnt < duty_act) ^ pol) : pol;
        end
    end

    // Pending shadow update flag for STATUS.UPD
    assign upd_c = (duty_sh != duty_act);

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM peripheral: shared prescaler and period counter, per-channel duty/polarity,
// double-buffered PERIOD/DUTY. Optional period-end interrupt under macro PWM_IRQ_EN.
module pwm_multi_ch
    import pwm_multi_ch_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CW   = 32,
    parameter logic [31:0] BASE = 32'h20
) (
    input  logic           clk,
    input  logic           res,
    input  logic           rd,
    input  logic           wr,
    input  logic [31:0]    addr,
    input  logic [31:0]    data_in,
    output logic [31:0]    data_out,
    output logic [NCH-1:0] pwm,
    output logic           irq
);

    localparam int unsigned NREG = REG_DUTY0 + NCH;

    logic [29:0]    widx;
    logic           mapped;
    logic           wr_hit;
    logic           unused_bits;

    logic           en;
    logic [NCH-1:0] pol;
    logic [CW-1:0]  presc;
    logic [CW-1:0]  psc;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  period_sh;
    logic [CW-1:0]  period_act;
    logic [CW-1:0]  duty_sh [NCH];
    logic [NCH-1:0] duty_upd;
    logic           tick;
    logic           wrap;
    logic           load;
    logic [31:0]    rdata_c;

    assign widx        = word_index(addr[31:2], BASE[31:2]);
    assign mapped      = (widx < 30'(NREG));
    assign wr_hit      = wr && mapped;
    assign unused_bits = ^{addr[1:0], data_in};

    assign tick = en && (psc == presc);
    assign wrap = tick && (cnt == period_act);
    assign load = wrap || !en;

    // Bus-writable control, prescaler and shadow registers
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            en        <= 1'b0;
            pol       <= '0;
            presc     <= '0;
            period_sh <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                duty_sh[i] <= '0;
            end
        end else if (wr_hit) begin
            if (widx == 30'(REG_CTRL)) begin
                en  <= data_in[CTRL_EN_BIT];
                pol <= data_in[CTRL_POL_LSB +: NCH];
            end
            if (widx == 30'(REG_PRESC)) begin
                presc <= data_in[CW-1:0];
            end
            if (widx == 30'(REG_PERIOD)) begin
                period_sh <= data_in[CW-1:0];
            end
            for (int i = 0; i < int'(NCH); i++) begin
                if (widx == 30'(REG_DUTY0 + i)) begin
                    duty_sh[i] <= data_in[CW-1:0];
                end
            end
        end
    end

    // Prescaler and period counter; both held at zero while disabled
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            psc <= '0;
            cnt <= '0;
        end else if (!en) begin
            psc <= '0;
            cnt <= '0;
        end else begin
            psc <= tick ? '0 : psc + CW'(1);
            if (tick) begin
                cnt <= (cnt == period_act) ? '0 : cnt + CW'(1);
            end
        end
    end

    // Active period follows the shadow on wrap or continuously while disabled
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            period_act <= '0;
        end else if (load) begin
            period_act <= period_sh;
        end
    end

    // Per-channel duty and output stage
    for (genvar gi = 0; gi < int'(NCH); gi++) begin : g_ch
        pwm_multi_ch_channel #(.CW(CW)) u_ch (
            .clk     (clk),
            .res     (res),
            .load    (load),
            .en      (en),
            .pol     (pol[gi]),
            .cnt     (cnt),
            .duty_sh (duty_sh[gi]),
            .pwm     (pwm[gi]),
            .upd_c   (duty_upd[gi])
        );
    end

`ifdef PWM_IRQ_EN
    logic irq_en;
    logic irq_en_n;
    logic pef;
    logic pef_n;

    // Next-state of flag and enable; a wrap wins over a same-cycle clear
    always_comb begin
        pef_n    = pef;
        irq_en_n = irq_en;
        if (wr_hit && widx == 30'(REG_CTRL)) begin
            irq_en_n = data_in[CTRL_IRQ_BIT];
        end
        if (wr_hit && widx == 30'(REG_STATUS) && data_in[STAT_PEF_BIT]) begin
            pef_n = 1'b0;
        end
        if (wrap) begin
            pef_n = 1'b1;
        end
    end

    // Period-end flag and interrupt output
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            irq_en <= 1'b0;
            pef    <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq_en <= irq_en_n;
            pef    <= pef_n;
            irq    <= pef_n && irq_en_n;
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Read mux; unmapped addresses return zero
    always_comb begin
        rdata_c = '0;
        if (mapped) begin
            if (widx == 30'(REG_CTRL)) begin
                rdata_c[CTRL_EN_BIT]           = en;
                rdata_c[CTRL_POL_LSB +: NCH]   = pol;
`ifdef PWM_IRQ_EN
                rdata_c[CTRL_IRQ_BIT]          = irq_en;
`endif
            end
            if (widx == 30'(REG_PRESC)) begin
                rdata_c[CW-1:0] = presc;
            end
            if (widx == 30'(REG_PERIOD)) begin
                rdata_c[CW-1:0] = period_sh;
            end
            if (widx == 30'(REG_STATUS)) begin
                rdata_c[STAT_UPD_BIT] = (period_sh != period_act) || (|duty_upd);
`ifdef PWM_IRQ_EN
                rdata_c[STAT_PEF_BIT] = pef;
`endif
            end
            for (int i = 0; i < int'(NCH); i++) begin
                if (widx == 30'(REG_DUTY0 + i)) begin
                    rdata_c[CW-1:0] = duty_sh[i];
                end
            end
        end
    end

    // Registered read data, held until the next read
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            data_out <= '0;
        end else if (rd) begin
            data_out <= rdata_c;
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench for pwm_multi_ch (default build, PWM_IRQ_EN undefined).
module tb_pwm_multi_ch;

    localparam int unsigned NCH = 4;

    logic           clk = 1'b0;
    logic           res;
    logic           rd;
    logic           wr;
    logic [31:0]    addr;
    logic [31:0]    data_in;
    logic [31:0]    data_out;
    logic [NCH-1:0] pwm;
    logic           irq;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    pwm_multi_ch #(.NCH(NCH), .CW(32), .BASE(32'h20)) dut (
        .clk      (clk),
        .res      (res),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .pwm      (pwm),
        .irq      (irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic sb_push(input string nm, input logic [31:0] exp);
        sb_t e;
        e.nm  = nm;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic sb_check();
        sb_t e;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk(e.nm, data_out, e.exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input string nm, input logic [31:0] exp);
        @(negedge clk);
        rd = 1'b1; addr = a;
        sb_push(nm, exp);
        @(negedge clk);
        rd = 1'b0;
        sb_check();
    endtask

    // Waits (bounded) for pwm[ch] to change to val; leaves at the first sample of the new level
    task automatic wait_edge(input int ch, input logic val, input string nm);
        logic prev;
        bit   ok;
        ok   = 1'b0;
        prev = pwm[ch];
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (prev != val && pwm[ch] == val) ok = 1'b1;
            prev = pwm[ch];
        end
        if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Counts consecutive samples at level val starting with the current sample
    task automatic run_len(input int ch, input logic val, output int n);
        n = 0;
        while (pwm[ch] == val && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int h[NCH];
        int h0;
        int h1;

        res = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;

        vecs[0]  = '{32'h20, 32'hFFFF_FF02, 32'h20, 32'h0000_0F00};
        vecs[1]  = '{32'h24, 32'hDEAD_BEEF, 32'h24, 32'hDEAD_BEEF};
        vecs[2]  = '{32'h28, 32'h1234_5678, 32'h28, 32'h1234_5678};
        vecs[3]  = '{32'h30, 32'h0000_0011, 32'h30, 32'h0000_0011};
        vecs[4]  = '{32'h34, 32'h0000_0022, 32'h34, 32'h0000_0022};
        vecs[5]  = '{32'h38, 32'h0000_0033, 32'h3A, 32'h0000_0033};
        vecs[6]  = '{32'h3C, 32'h0000_0044, 32'h3C, 32'h0000_0044};
        vecs[7]  = '{32'h40, 32'h0000_0055, 32'h40, 32'h0000_0000};
        vecs[8]  = '{32'h60, 32'h0000_0066, 32'h60, 32'h0000_0000};
        vecs[9]  = '{32'h1C, 32'h0000_0077, 32'h1C, 32'h0000_0000};
        vecs[10] = '{32'h2C, 32'hFFFF_FFFF, 32'h2C, 32'h0000_0000};

        // Power-on reset
        repeat (3) @(negedge clk);
        chk("rst_pwm", 32'(pwm), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        res = 1'b0;

        // Register write/readback table (EN stays 0)
        foreach (vecs[i]) begin
            bus_write(vecs[i].waddr, vecs[i].wdata);
            bus_read(vecs[i].raddr, $sformatf("reg_vec%0d", i), vecs[i].exp);
        end
        bus_read(32'h3C, "duty3_not_clobbered", 32'h44);

        // Basic run: PERIOD=9, duties 3 / 0 / 20 / 10
        bus_write(32'h20, 32'h0);
        bus_write(32'h24, 32'd0);
        bus_write(32'h28, 32'd9);
        bus_write(32'h30, 32'd3);
        bus_write(32'h34, 32'd0);
        bus_write(32'h38, 32'd20);
        bus_write(32'h3C, 32'd10);
        bus_write(32'h20, 32'h1);
        repeat (5) @(negedge clk);
        for (int c = 0; c < int'(NCH); c++) h[c] = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            for (int c = 0; c < int'(NCH); c++) h[c] += int'(pwm[c]);
        end
        chk("basic_duty3_highs", 32'(h[0]), 32'd9);
        chk("basic_duty0_highs", 32'(h[1]), 32'd0);
        chk("basic_duty20_highs", 32'(h[2]), 32'd30);
        chk("basic_duty_gt_period_highs", 32'(h[3]), 32'd30);
        chk("irq_tied_low", 32'(irq), 32'd0);

        // Shadow: DUTY0=7 written during the high phase of a period
        wait_edge(0, 1'b1, "shadow_rise");
        h0 = 0; h1 = 0;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) @(negedge clk);
            if (j < 10) h0 += int'(pwm[0]); else h1 += int'(pwm[0]);
            if (j == 6 || j == 13) sb_check();
            wr      = (j == 1);
            addr    = (j == 1) ? 32'h30 : 32'h2C;
            data_in = 32'd7;
            rd      = (j == 5 || j == 12);
            if (j == 5)  sb_push("shadow_upd_pending", 32'h2);
            if (j == 12) sb_push("shadow_upd_cleared", 32'h0);
        end
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        chk("shadow_cur_period", 32'(h0), 32'd3);
        chk("shadow_next_period", 32'(h1), 32'd7);

        // Prescaler + polarity: idle level first, then PRESC=3 PERIOD=4 DUTY0=2 POL0=1
        bus_write(32'h20, 32'h100);
        @(negedge clk);
        chk("idle_pol_level", 32'(pwm), 32'h1);
        bus_write(32'h24, 32'd3);
        bus_write(32'h28, 32'd4);
        bus_write(32'h30, 32'd2);
        bus_write(32'h20, 32'h101);
        @(negedge clk);
        run_len(0, 1'b0, n);
        chk("presc_first_low", 32'(n), 32'd8);
        run_len(0, 1'b1, n);
        chk("presc_high", 32'(n), 32'd12);
        run_len(0, 1'b0, n);
        chk("presc_low", 32'(n), 32'd8);

        // Disable mid-period, then restart from cnt=0
        repeat (2) @(negedge clk);
        bus_write(32'h20, 32'h100);
        @(negedge clk);
        chk("disable_pol_level", 32'(pwm), 32'h1);
        bus_write(32'h20, 32'h101);
        @(negedge clk);
        run_len(0, 1'b0, n);
        chk("restart_low", 32'(n), 32'd8);

        // rd+wr same cycle returns the pre-write value
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; addr = 32'h30; data_in = 32'h99;
        sb_push("rdwr_old_value", 32'd2);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        sb_check();
        bus_read(32'h30, "rdwr_new_value", 32'h99);

        // Reset mid-run for 5 clocks
        @(negedge clk);
        res = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_pwm", 32'(pwm), 32'd0);
        chk("midrst_data_out", data_out, 32'd0);
        chk("midrst_irq", 32'(irq), 32'd0);
        res = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus_read(32'h20 + 32'(4 * k), $sformatf("midrst_reg%0d", k), 32'd0);
        end
        repeat (3) @(negedge clk);
        chk("midrst_pwm_idle", 32'(pwm), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
